// File: rtl/ahb3lite_pkg.sv
// Shared helper state types and small arithmetic helpers for the AHB3-Lite helper blocks.
package ahb3lite_pkg;

  typedef enum logic [1:0] {
    Writer_IDLE    = 2'd0,
    Writer_COLLECT = 2'd1,
    Writer_STALL   = 2'd2
  } FIFO_Writer_Help_state;

  function automatic logic [15:0] ceil_words(input logic [15:0] len);
    logic [16:0] t;
    t = {1'b0, len} + 17'd3;
    return {1'b0, t[16:2]};
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fifo_writer_helper_if.sv
// Byte-stream / FIFO-write bundle for fifo_writer_helper.
// Optional FIFO_WRITER_STATS_EN adds the frame and drop counters.
interface fifo_writer_helper_if #(parameter int LEN_W = 6);
  logic             Write_Request;
  logic [LEN_W-1:0] i_WCC_BUFFER_LENGTH;
  logic [7:0]       serialized_input;
  logic             serialized_input_valid;
  logic             serialized_input_ready;
  logic             i_FIFO_full;
  logic [31:0]      o_FIFO_din;
  logic             o_FIFO_wr_en;
  logic             o_busy;
  logic             o_frame_done;
  logic [15:0]      Bytes_Counter;
`ifdef FIFO_WRITER_STATS_EN
  logic [15:0]      o_frame_count;
  logic [15:0]      o_drop_count;
`endif

  modport master (
    output Write_Request, i_WCC_BUFFER_LENGTH, serialized_input, serialized_input_valid, i_FIFO_full,
    input  serialized_input_ready, o_FIFO_din, o_FIFO_wr_en, o_busy, o_frame_done, Bytes_Counter
`ifdef FIFO_WRITER_STATS_EN
    , input o_frame_count, o_drop_count
`endif
  );

  modport slave (
    input  Write_Request, i_WCC_BUFFER_LENGTH, serialized_input, serialized_input_valid, i_FIFO_full,
    output serialized_input_ready, o_FIFO_din, o_FIFO_wr_en, o_busy, o_frame_done, Bytes_Counter
`ifdef FIFO_WRITER_STATS_EN
    , output o_frame_count, o_drop_count
`endif
  );
endinterface

// File: rtl/fifo_writer_helper.sv
// Packs a byte stream into little-endian 32-bit FIFO words, one frame per Write_Request.
// Define FIFO_WRITER_STATS_EN to add saturating frame/drop counters.
module fifo_writer_helper
  import ahb3lite_pkg::*;
#(
  parameter int LEN_W = 6
) (
  input  logic                 CLK,
  input  logic                 RESET,
  fifo_writer_helper_if.slave  bus
);

  FIFO_Writer_Help_state state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [15:0]      words_n_q, words_n_d;
  logic [15:0]      words_done_q, words_done_d;
  logic [15:0]      bytes_q, bytes_d;
  logic [31:0]      word_q, word_d;
  logic [31:0]      din_q, din_d;
  logic             wr_en_q, wr_en_d;
  logic             done_q, done_d;

  logic [31:0]      merged_s;
  logic             word_end_s;
  logic             last_word_s;

  assign merged_s    = word_q | ({24'd0, bus.serialized_input} << {bytes_q[1:0], 3'b000});
  assign word_end_s  = (bytes_q[1:0] == 2'd3) || ((bytes_q + 16'd1) == 16'(len_q));
  assign last_word_s = (words_done_q + 16'd1) == words_n_q;

  // Next-state and output computation; word_q doubles as the stall holding register.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    words_n_d    = words_n_q;
    words_done_d = words_done_q;
    bytes_d      = bytes_q;
    word_d       = word_q;
    din_d        = din_q;
    wr_en_d      = 1'b0;
    done_d       = 1'b0;
    case (state_q)
      Writer_IDLE: begin
        if (bus.Write_Request && (bus.i_WCC_BUFFER_LENGTH != {LEN_W{1'b0}})) begin
          len_d        = bus.i_WCC_BUFFER_LENGTH;
          words_n_d    = ceil_words(16'(bus.i_WCC_BUFFER_LENGTH));
          words_done_d = 16'd0;
          bytes_d      = 16'd0;
          word_d       = 32'd0;
          state_d      = Writer_COLLECT;
        end else begin
          state_d = Writer_IDLE;
        end
      end
      Writer_COLLECT: begin
        if (bus.serialized_input_valid) begin
          bytes_d = bytes_q + 16'd1;
          if (word_end_s) begin
            if (!bus.i_FIFO_full) begin
              din_d        = merged_s;
              wr_en_d      = 1'b1;
              word_d       = 32'd0;
              words_done_d = words_done_q + 16'd1;
              if (last_word_s) begin
                done_d  = 1'b1;
                state_d = Writer_IDLE;
              end else begin
                state_d = Writer_COLLECT;
              end
            end else begin
              word_d  = merged_s;
              state_d = Writer_STALL;
            end
          end else begin
            word_d = merged_s;
          end
        end else begin
          state_d = Writer_COLLECT;
        end
      end
      Writer_STALL: begin
        if (!bus.i_FIFO_full) begin
          din_d        = word_q;
          wr_en_d      = 1'b1;
          word_d       = 32'd0;
          words_done_d = words_done_q + 16'd1;
          if (last_word_s) begin
            done_d  = 1'b1;
            state_d = Writer_IDLE;
          end else begin
            state_d = Writer_COLLECT;
          end
        end else begin
          state_d = Writer_STALL;
        end
      end
      default: begin
        state_d = Writer_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= Writer_IDLE;
      len_q        <= {LEN_W{1'b0}};
      words_n_q    <= 16'd0;
      words_done_q <= 16'd0;
      bytes_q      <= 16'd0;
      word_q       <= 32'd0;
      din_q        <= 32'd0;
      wr_en_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      words_n_q    <= words_n_d;
      words_done_q <= words_done_d;
      bytes_q      <= bytes_d;
      word_q       <= word_d;
      din_q        <= din_d;
      wr_en_q      <= wr_en_d;
      done_q       <= done_d;
    end
  end

  assign bus.serialized_input_ready = (state_q == Writer_COLLECT);
  assign bus.o_busy                 = (state_q != Writer_IDLE);
  assign bus.o_FIFO_din             = din_q;
  assign bus.o_FIFO_wr_en           = wr_en_q;
  assign bus.o_frame_done           = done_q;
  assign bus.Bytes_Counter          = bytes_q;

`ifdef FIFO_WRITER_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Drops are bytes offered while the block is not collecting.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (done_d) begin
      frame_cnt_d = sat_inc16(frame_cnt_q);
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
    if (bus.serialized_input_valid && (state_q != Writer_COLLECT)) begin
      drop_cnt_d = sat_inc16(drop_cnt_q);
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      frame_cnt_q <= 16'd0;
      drop_cnt_q  <= 16'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign bus.o_frame_count = frame_cnt_q;
  assign bus.o_drop_count  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_writer_helper.sv
// Self-checking bench for fifo_writer_helper: vector table, hand-written corner cases,
// and randomized frames compared with a byte-packing reference model.
module tb_fifo_writer_helper;

  typedef struct {
    int          len;
    logic [7:0]  b [8];
    int          nw;
    logic [31:0] w [2];
  } vec_t;

  typedef struct {
    logic [31:0] din;
    logic        done;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_writer_helper_if #(.LEN_W(6)) bus();
  fifo_writer_helper #(.LEN_W(6)) dut (.CLK(clk), .RESET(rst), .bus(bus));

  int n_cmp  = 0;
  int n_fail = 0;

  wr_t        obs_q[$];
  int         done_cnt = 0;
  int         viol_cnt = 0;
  logic       full_prev;
  logic [7:0] frame_bytes[$];

  // Full as the DUT saw it on the most recent rising edge.
  always @(posedge clk or posedge rst) begin
    if (rst) full_prev <= 1'b0;
    else     full_prev <= bus.i_FIFO_full;
  end

  // Write monitor: records every FIFO write and flags protocol violations.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_FIFO_wr_en) obs_q.push_back('{din: bus.o_FIFO_din, done: bus.o_frame_done});
      if (bus.o_FIFO_wr_en && full_prev) viol_cnt <= viol_cnt + 1;
      if (bus.o_frame_done && !bus.o_FIFO_wr_en) viol_cnt <= viol_cnt + 1;
      if (bus.o_frame_done) done_cnt <= done_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_idle_zero(input string name);
    check({name, "_din"},   bus.o_FIFO_din, 32'd0);
    check({name, "_wr"},    {31'd0, bus.o_FIFO_wr_en}, 32'd0);
    check({name, "_ready"}, {31'd0, bus.serialized_input_ready}, 32'd0);
    check({name, "_busy"},  {31'd0, bus.o_busy}, 32'd0);
    check({name, "_done"},  {31'd0, bus.o_frame_done}, 32'd0);
    check({name, "_bytes"}, {16'd0, bus.Bytes_Counter}, 32'd0);
  endtask

  // Reference packing: byte i of the frame lands in word i/4 at bit 8*(i%4).
  function automatic void model_words(input int len, output logic [31:0] w_q[$]);
    w_q = {};
    for (int i = 0; i * 4 < len; i++) begin
      logic [31:0] w;
      w = 32'd0;
      for (int j = 0; j < 4; j++)
        if (i * 4 + j < len) w = w | (32'(frame_bytes[i * 4 + j]) << (8 * j));
      w_q.push_back(w);
    end
  endfunction

  task automatic send_frame(input int len, input int full_pct, input int gap_pct, input bit inject);
    int idx;
    int guard;
    int d0;
    d0 = done_cnt;
    @(negedge clk);
    bus.Write_Request       = 1'b1;
    bus.i_WCC_BUFFER_LENGTH = 6'(len);
    @(negedge clk);
    bus.Write_Request = 1'b0;
    idx   = 0;
    guard = 0;
    while (done_cnt == d0 && guard < 2000) begin
      bus.i_FIFO_full = ($urandom_range(0, 99) < full_pct);
      if (idx < len && $urandom_range(0, 99) >= gap_pct) begin
        bus.serialized_input_valid = 1'b1;
        bus.serialized_input       = frame_bytes[idx];
      end else begin
        bus.serialized_input_valid = 1'b0;
        bus.serialized_input       = 8'($urandom);
      end
      if (inject && idx == 2 && idx < len) begin
        bus.Write_Request       = 1'b1;
        bus.i_WCC_BUFFER_LENGTH = 6'($urandom_range(0, 63));
      end else begin
        bus.Write_Request = 1'b0;
      end
      if (bus.serialized_input_valid && bus.serialized_input_ready) idx++;
      @(negedge clk);
      guard++;
    end
    bus.serialized_input_valid = 1'b0;
    bus.Write_Request          = 1'b0;
    bus.i_FIFO_full            = 1'b0;
    check("frame_timeout", 32'(guard >= 2000), 32'd0);
  endtask

  task automatic check_words(input string name, input int len, input logic [31:0] exp_q[$], input int rd0);
    check({name, "_nwords"}, 32'(obs_q.size() - rd0), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (rd0 + i < obs_q.size()) begin
        check({name, "_word"}, obs_q[rd0 + i].din, exp_q[i]);
        check({name, "_done"}, {31'd0, obs_q[rd0 + i].done}, 32'(i == exp_q.size() - 1));
      end
    end
    check({name, "_bytes"}, {16'd0, bus.Bytes_Counter}, 32'(len));
    check({name, "_busy"},  {31'd0, bus.o_busy}, 32'd0);
    check({name, "_viol"},  32'(viol_cnt), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[6];
    logic [31:0] exp_q[$];
    int          rd0;

    vecs[0].len = 8; vecs[0].b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    vecs[0].nw  = 2; vecs[0].w = '{32'h04030201, 32'h08070605};
    vecs[1].len = 5; vecs[1].b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'h00, 8'h00, 8'h00};
    vecs[1].nw  = 2; vecs[1].w = '{32'hDDCCBBAA, 32'h000000EE};
    vecs[2].len = 3; vecs[2].b = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[2].nw  = 1; vecs[2].w = '{32'h00332211, 32'h0};
    vecs[3].len = 1; vecs[3].b = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[3].nw  = 1; vecs[3].w = '{32'h0000005A, 32'h0};
    vecs[4].len = 7; vecs[4].b = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h00};
    vecs[4].nw  = 2; vecs[4].w = '{32'h13121110, 32'h00161514};
    vecs[5].len = 4; vecs[5].b = '{8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[5].nw  = 1; vecs[5].w = '{32'hF4F3F2F1, 32'h0};

    bus.Write_Request          = 1'b0;
    bus.i_WCC_BUFFER_LENGTH    = 6'd0;
    bus.serialized_input       = 8'd0;
    bus.serialized_input_valid = 1'b0;
    bus.i_FIFO_full            = 1'b0;
    #1;
    check_idle_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_idle_zero("after_reset");

    // Vector table, back-to-back bytes, FIFO never full.
    for (int v = 0; v < 6; v++) begin
      frame_bytes = {};
      for (int i = 0; i < vecs[v].len; i++) frame_bytes.push_back(vecs[v].b[i]);
      exp_q = {};
      for (int i = 0; i < vecs[v].nw; i++) exp_q.push_back(vecs[v].w[i]);
      rd0 = obs_q.size();
      send_frame(vecs[v].len, 0, 0, 1'b0);
      check_words($sformatf("vec%0d", v), vecs[v].len, exp_q, rd0);
    end

    // Request while busy, with a different length, must not disturb the frame.
    frame_bytes = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    rd0 = obs_q.size();
    send_frame(8, 0, 0, 1'b1);
    check_words("busy_req", 8, '{32'h04030201, 32'h08070605}, rd0);

    // FIFO full for three cycles starting at the completion cycle.
    rd0 = obs_q.size();
    @(negedge clk);
    bus.Write_Request = 1'b1; bus.i_WCC_BUFFER_LENGTH = 6'd4;
    @(negedge clk);
    bus.Write_Request = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("stall_ready_collect", {31'd0, bus.serialized_input_ready}, 32'd1);
      bus.serialized_input_valid = 1'b1;
      bus.serialized_input       = 8'(i + 1);
      bus.i_FIFO_full            = (i == 3);
      @(negedge clk);
    end
    bus.serialized_input = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      bus.i_FIFO_full = (c < 2);
      check("stall_ready", {31'd0, bus.serialized_input_ready}, 32'd0);
      check("stall_wr",    {31'd0, bus.o_FIFO_wr_en}, 32'd0);
      @(negedge clk);
    end
    bus.serialized_input_valid = 1'b0;
    check("stall_release_wr",   {31'd0, bus.o_FIFO_wr_en}, 32'd1);
    check("stall_release_din",  bus.o_FIFO_din, 32'h04030201);
    check("stall_release_done", {31'd0, bus.o_frame_done}, 32'd1);
    @(negedge clk);
    check("stall_after_wr", {31'd0, bus.o_FIFO_wr_en}, 32'd0);
    check("stall_nwrites", 32'(obs_q.size() - rd0), 32'd1);
    check("stall_bytes", {16'd0, bus.Bytes_Counter}, 32'd4);

    // Reset in the middle of a frame.
    rd0 = obs_q.size();
    bus.Write_Request = 1'b1; bus.i_WCC_BUFFER_LENGTH = 6'd8;
    @(negedge clk);
    bus.Write_Request = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.serialized_input_valid = 1'b1;
      bus.serialized_input       = 8'(8'hC0 + i);
      @(negedge clk);
    end
    bus.serialized_input_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check_idle_zero("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.serialized_input_valid = 1'b1;
      bus.serialized_input       = 8'($urandom);
      @(negedge clk);
    end
    bus.serialized_input_valid = 1'b0;
    @(negedge clk);
    check("reset_no_write", 32'(obs_q.size() - rd0), 32'd0);
    frame_bytes = {8'h31, 8'h32, 8'h33, 8'h34};
    rd0 = obs_q.size();
    send_frame(4, 0, 0, 1'b0);
    check_words("post_reset", 4, '{32'h34333231}, rd0);

    // Zero-length request is ignored.
    @(negedge clk);
    bus.Write_Request = 1'b1; bus.i_WCC_BUFFER_LENGTH = 6'd0;
    @(negedge clk);
    bus.Write_Request = 1'b0;
    check("zero_len_busy",  {31'd0, bus.o_busy}, 32'd0);
    check("zero_len_ready", {31'd0, bus.serialized_input_ready}, 32'd0);
    check("zero_len_bytes", {16'd0, bus.Bytes_Counter}, 32'd4);

`ifdef FIFO_WRITER_STATS_EN
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.serialized_input_valid = 1'b1;
      bus.serialized_input       = 8'($urandom);
      @(negedge clk);
    end
    bus.serialized_input_valid = 1'b0;
    @(negedge clk);
    check("drop_count",  {16'd0, bus.o_drop_count}, 32'd3);
    check("frame_count0", {16'd0, bus.o_frame_count}, 32'd0);
    frame_bytes = {8'h01, 8'h02};
    send_frame(2, 0, 0, 1'b0);
    check("frame_count1", {16'd0, bus.o_frame_count}, 32'd1);
`endif

    // Randomized frames against the reference model.
    for (int f = 0; f < 25; f++) begin
      int len;
      len = $urandom_range(1, 63);
      frame_bytes = {};
      for (int i = 0; i < len; i++) frame_bytes.push_back(8'($urandom));
      model_words(len, exp_q);
      rd0 = obs_q.size();
      send_frame(len, $urandom_range(0, 40), $urandom_range(0, 30), 1'($urandom_range(0, 1)));
      check_words($sformatf("rand%0d", f), len, exp_q, rd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_writer_helper.md
FIFO_WRITER_HELPER -- requirements
Module: fifo_writer_helper

Interface
REQ-001 SHALL have parameter LEN_W, default 6, width of the frame byte-length input.
REQ-002 SHALL have port CLK  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port Write_Request  input  1  frame start; sampled only in Writer_IDLE.
REQ-005 SHALL have port i_WCC_BUFFER_LENGTH  input  LEN_W  frame length in bytes; latched on accepted Write_Request.
REQ-006 SHALL have port serialized_input  input  8  byte data.
REQ-007 SHALL have port serialized_input_valid  input  1  byte present.
REQ-008 SHALL have port serialized_input_ready  output  1  byte accepted when valid and ready are both high.
REQ-009 SHALL have port i_FIFO_full  input  1  downstream FIFO full.
REQ-010 SHALL have port o_FIFO_din  output  32  packed word, registered.
REQ-011 SHALL have port o_FIFO_wr_en  output  1  one-cycle write strobe, registered.
REQ-012 SHALL have port o_busy  output  1  high in any state other than Writer_IDLE.
REQ-013 SHALL have port o_frame_done  output  1  one-cycle pulse coincident with the final word write of a frame.
REQ-014 SHALL have port Bytes_Counter  output  16  bytes accepted in the current frame.

Function
REQ-015 SHALL implement states Writer_IDLE, Writer_COLLECT and Writer_STALL.
REQ-016 Writer_IDLE: on Write_Request with nonzero length, latch length, set Words_N = ceil(len/4), clear byte lane, clear Bytes_Counter, go to Writer_COLLECT; a zero-length request SHALL be ignored.
REQ-017 serialized_input_ready SHALL be 1 in Writer_COLLECT only; valid bytes in Writer_IDLE or Writer_STALL SHALL be ignored.
REQ-018 The k-th accepted byte of a word (k = Bytes_Counter[1:0] before increment) SHALL be placed little-endian: first byte at [7:0], fourth byte at [31:24].
REQ-019 A word SHALL complete on its 4th accepted byte, or on the byte that makes Bytes_Counter equal the latched length; unfilled lanes SHALL be zero.
REQ-020 If i_FIFO_full is 0 in completion cycle N, o_FIFO_din SHALL be loaded and o_FIFO_wr_en SHALL be 1 in cycle N+1, with the lane reset for the next word and no lost cycle.
REQ-021 If i_FIFO_full is 1 in cycle N, the block SHALL enter Writer_STALL, hold the word, and assert o_FIFO_wr_en in the cycle after the first cycle with i_FIFO_full = 0, then resume Writer_COLLECT.
REQ-022 After the final word (word count = Words_N) is written, the block SHALL pulse o_frame_done with that o_FIFO_wr_en and return to Writer_IDLE.
REQ-023 Write_Request while o_busy is high SHALL be ignored; a length change mid-frame SHALL have no effect.
REQ-024 o_FIFO_wr_en SHALL never be high while i_FIFO_full was high in the preceding cycle.

Reset
REQ-025 RESET SHALL asynchronously force Writer_IDLE with every output and counter at 0 (o_FIFO_din = 0, o_FIFO_wr_en = 0, ready = 0, o_busy = 0, o_frame_done = 0, Bytes_Counter = 0).
REQ-026 A reset mid-frame SHALL discard the partial word, and no write SHALL occur after deassertion until a new frame is started.

Configuration
REQ-027 With FIFO_WRITER_STATS_EN defined, the block SHALL add outputs o_frame_count[15:0] (frames completed) and o_drop_count[15:0] (valid bytes ignored outside Writer_COLLECT); both SHALL saturate at 16'hFFFF and clear on RESET.
REQ-028 Without FIFO_WRITER_STATS_EN, these ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-029 The state enum FIFO_Writer_Help_state (Writer_IDLE, Writer_COLLECT, Writer_STALL) SHALL reside in ahb3lite_pkg, alongside the existing helper state types.
REQ-030 The block SHALL be a single module with no sub-modules.

Verification
REQ-031 The bench SHALL cover: len = 8, bytes 01..08 back-to-back, FIFO never full -> writes 32'h04030201 then 32'h08070605, o_frame_done with the second write.
REQ-032 The bench SHALL cover: len = 5, bytes AA BB CC DD EE -> writes 32'hDDCCBBAA then 32'h000000EE, Bytes_Counter = 5.
REQ-033 The bench SHALL cover: len = 4, i_FIFO_full = 1 for 3 cycles at completion -> ready = 0 for the stall, exactly one write of the word after full drops.
REQ-034 The bench SHALL cover: RESET pulsed after 2 of 8 bytes -> all outputs 0 immediately, no write afterwards, next frame of len = 4 packs correctly.
REQ-035 The bench SHALL cover: Write_Request with len = 0, and Write_Request while busy -> no state change; with FIFO_WRITER_STATS_EN, 3 stray bytes in Writer_IDLE -> o_drop_count = 3.
